// File: rtl/mem_stage_pkg.sv
// Shared types and geometry for the MEM stage and its data cache.
package mem_stage_pkg;

  localparam int unsigned ADDR_W_DEF     = 32;
  localparam int unsigned INDEX_BITS_DEF = 6;
  localparam int unsigned TAG_BITS_DEF   = ADDR_W_DEF - INDEX_BITS_DEF - 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DONE    = 2'd3
  } state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Direct-mapped cache storage: valid/tag/data, async read, one sync write port.
module dcache_array
  import mem_stage_pkg::*;
#(
  parameter int unsigned INDEX_BITS = INDEX_BITS_DEF,
  parameter int unsigned TAG_BITS   = TAG_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [31:0]           rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [31:0]           wr_data
);

  localparam int unsigned LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid_q;
  logic [LINES-1:0]    valid_d;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [31:0]         data_mem [LINES];

  always_comb begin
    valid_d = valid_q;
    if (wr_en) valid_d[wr_index] = 1'b1;
  end

  // Only the valid bits are reset; stale tag/data are harmless once invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

  always_comb begin
    rd_valid = valid_q[rd_index];
    rd_tag   = tag_mem[rd_index];
    rd_data  = data_mem[rd_index];
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: write-through, no-write-allocate D-cache plus branch resolve.
// Define DCACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned INDEX_BITS = INDEX_BITS_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] alu_result_in,
  input  logic [31:0]       store_data_in,
  input  logic [4:0]        rd_addr_in,
  input  logic              mem_to_reg_in,
  input  logic              reg_write_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              branch_in,
  input  logic              zero_in,
  input  logic [31:0]       branch_target_in,
  output logic [31:0]       read_data_out,
  output logic [ADDR_W-1:0] alu_result_out,
  output logic [4:0]        rd_addr_out,
  output logic              mem_to_reg_out,
  output logic              reg_write_out,
  output logic              pc_src_out,
  output logic [31:0]       branch_target_out,
  output logic              mem_stall_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int unsigned TAG_BITS = ADDR_W - INDEX_BITS - 2;

  state_e              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [31:0]         resp_q, resp_d;
  logic                load_q, load_d;

  logic [INDEX_BITS-1:0] lk_index;
  logic [TAG_BITS-1:0]   lk_tag;
  logic                  arr_valid;
  logic [TAG_BITS-1:0]   arr_tag;
  logic [31:0]           arr_data;
  logic                  hit;
  logic                  fill_en;
  logic [31:0]           fill_data;
  logic                  stall;
  logic [31:0]           rdata;
  logic                  hit_evt;
  logic                  miss_evt;

  assign lk_index = alu_result_in[INDEX_BITS+1:2];
  assign lk_tag   = alu_result_in[ADDR_W-1:INDEX_BITS+2];

  dcache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_dcache_array (
    .clk      (clk),
    .rst      (rst),
    .rd_index (lk_index),
    .rd_valid (arr_valid),
    .rd_tag   (arr_tag),
    .rd_data  (arr_data),
    .wr_en    (fill_en),
    .wr_index (mem_addr_q[INDEX_BITS+1:2]),
    .wr_tag   (mem_addr_q[ADDR_W-1:INDEX_BITS+2]),
    .wr_data  (fill_data)
  );

  assign hit = arr_valid && (arr_tag == lk_tag);

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    resp_d      = resp_q;
    load_d      = load_q;
    stall       = 1'b0;
    rdata       = '0;
    fill_en     = 1'b0;
    fill_data   = mem_rdata;
    hit_evt     = 1'b0;
    miss_evt    = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_write_in) begin
          stall       = 1'b1;
          mem_addr_d  = {alu_result_in[ADDR_W-1:2], 2'b00};
          mem_wdata_d = store_data_in;
          load_d      = 1'b0;
          state_d     = WR_WAIT;
        end else if (mem_read_in) begin
          if (hit) begin
            rdata   = arr_data;
            hit_evt = 1'b1;
          end else begin
            stall      = 1'b1;
            mem_addr_d = {alu_result_in[ADDR_W-1:2], 2'b00};
            load_d     = 1'b1;
            miss_evt   = 1'b1;
            state_d    = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        stall = 1'b1;
        if (mem_ack) begin
          fill_en = 1'b1;
          resp_d  = mem_rdata;
          state_d = DONE;
        end
      end
      WR_WAIT: begin
        stall = 1'b1;
        // Write-through: refresh the line only if already present.
        if (mem_ack) begin
          fill_en   = hit;
          fill_data = mem_wdata_q;
          state_d   = DONE;
        end
      end
      DONE: begin
        rdata   = load_q ? resp_q : '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    mem_req_d = (state_d == RD_WAIT) || (state_d == WR_WAIT);
    mem_we_d  = (state_d == WR_WAIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      resp_q      <= '0;
      load_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      resp_q      <= resp_d;
      load_q      <= load_d;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_evt  ? sat_inc(hit_count_q)  : hit_count_q;
    miss_count_d = miss_evt ? sat_inc(miss_count_q) : miss_count_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  logic unused_evt;
  assign unused_evt = hit_evt ^ miss_evt;
`endif

  assign read_data_out     = rdata;
  assign mem_stall_out     = stall;
  assign mem_req           = mem_req_q;
  assign mem_we            = mem_we_q;
  assign mem_addr          = mem_addr_q;
  assign mem_wdata         = mem_wdata_q;
  assign alu_result_out    = alu_result_in;
  assign rd_addr_out       = rd_addr_in;
  assign mem_to_reg_out    = mem_to_reg_in;
  assign reg_write_out     = reg_write_in && !stall;
  assign pc_src_out        = branch_in && zero_in;
  assign branch_target_out = branch_target_in;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] alu_result_in = '0;
  logic [31:0] store_data_in = '0;
  logic [4:0]  rd_addr_in = '0;
  logic        mem_to_reg_in = 1'b0;
  logic        reg_write_in = 1'b0;
  logic        mem_read_in = 1'b0;
  logic        mem_write_in = 1'b0;
  logic        branch_in = 1'b0;
  logic        zero_in = 1'b0;
  logic [31:0] branch_target_in = '0;
  logic [31:0] read_data_out;
  logic [31:0] alu_result_out;
  logic [4:0]  rd_addr_out;
  logic        mem_to_reg_out;
  logic        reg_write_out;
  logic        pc_src_out;
  logic [31:0] branch_target_out;
  logic        mem_stall_out;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk               (clk),
    .rst               (rst),
    .alu_result_in     (alu_result_in),
    .store_data_in     (store_data_in),
    .rd_addr_in        (rd_addr_in),
    .mem_to_reg_in     (mem_to_reg_in),
    .reg_write_in      (reg_write_in),
    .mem_read_in       (mem_read_in),
    .mem_write_in      (mem_write_in),
    .branch_in         (branch_in),
    .zero_in           (zero_in),
    .branch_target_in  (branch_target_in),
    .read_data_out     (read_data_out),
    .alu_result_out    (alu_result_out),
    .rd_addr_out       (rd_addr_out),
    .mem_to_reg_out    (mem_to_reg_out),
    .reg_write_out     (reg_write_out),
    .pc_src_out        (pc_src_out),
    .branch_target_out (branch_target_out),
    .mem_stall_out     (mem_stall_out),
    .mem_req           (mem_req),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_rdata         (mem_rdata),
    .mem_ack           (mem_ack)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count         (hit_count),
    .miss_count        (miss_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    mem_read_in  = 1'b0;
    mem_write_in = 1'b0;
    reg_write_in = 1'b0;
    mem_to_reg_in = 1'b0;
    alu_result_in = '0;
    store_data_in = '0;
  endtask

  task automatic drive_load(input logic [31:0] addr);
    set_idle();
    alu_result_in = addr;
    mem_read_in   = 1'b1;
    mem_to_reg_in = 1'b1;
    reg_write_in  = 1'b1;
    rd_addr_in    = 5'd9;
  endtask

  task automatic drive_store(input logic [31:0] addr, input logic [31:0] data);
    set_idle();
    alu_result_in = addr;
    store_data_in = data;
    mem_write_in  = 1'b1;
  endtask

  // Runs one transaction from its IDLE cycle; acks on the ack_on-th request cycle.
  // Returns at the negedge of the first non-stalled cycle.
  task automatic wait_mem(input int ack_on, input logic [31:0] rdata,
                          output int stalls, output int req_cycles,
                          output logic [31:0] req_addr, output logic req_we,
                          output logic [31:0] req_wdata, output logic rw_leak,
                          output logic timed_out);
    stalls = 0; req_cycles = 0; req_addr = '0; req_we = 1'b0;
    req_wdata = '0; rw_leak = 1'b0; timed_out = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!mem_stall_out) begin
        timed_out = 1'b0;
        break;
      end
      stalls++;
      if (reg_write_out) rw_leak = 1'b1;
      if (mem_req) begin
        req_cycles++;
        if (req_cycles == 1) begin
          req_addr  = mem_addr;
          req_we    = mem_we;
          req_wdata = mem_wdata;
        end
        if (req_cycles == ack_on) begin
          mem_ack   = 1'b1;
          mem_rdata = rdata;
        end
      end
      tick();
      mem_ack   = 1'b0;
      mem_rdata = '0;
    end
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", mem_req); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", mem_we); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
    n_cmp++; if (mem_stall_out !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", mem_stall_out); end
    n_cmp++; if (read_data_out !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", read_data_out); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load_miss();
    int st, rc; logic [31:0] ra, rw; logic we, leak, to;
    drive_load(32'h0000_0100);
    wait_mem(3, 32'hDEAD_BEEF, st, rc, ra, we, rw, leak, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL miss_timeout: got %b want 0", to); end
    n_cmp++; if (st !== 4) begin n_bad++; $display("FAIL miss_stalls: got %0d want 4", st); end
    n_cmp++; if (rc !== 3) begin n_bad++; $display("FAIL miss_req_cycles: got %0d want 3", rc); end
    n_cmp++; if (ra !== 32'h100) begin n_bad++; $display("FAIL miss_addr: got %h want 100", ra); end
    n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL miss_we: got %b want 0", we); end
    n_cmp++; if (leak !== 1'b0) begin n_bad++; $display("FAIL miss_regwrite_stall: got %b want 0", leak); end
    n_cmp++; if (read_data_out !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL miss_done_data: got %h want deadbeef", read_data_out); end
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL miss_done_req: got %b want 0", mem_req); end
    n_cmp++; if (reg_write_out !== 1'b1) begin n_bad++; $display("FAIL miss_done_regwrite: got %b want 1", reg_write_out); end
    set_idle();
    tick();
  endtask

  task automatic test_load_hit();
    drive_load(32'h0000_0100);
    @(negedge clk);
    n_cmp++; if (mem_stall_out !== 1'b0) begin n_bad++; $display("FAIL hit_stall: got %b want 0", mem_stall_out); end
    n_cmp++; if (read_data_out !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL hit_data: got %h want deadbeef", read_data_out); end
    n_cmp++; if (reg_write_out !== 1'b1) begin n_bad++; $display("FAIL hit_regwrite: got %b want 1", reg_write_out); end
    alu_result_in = 32'h0000_0102;
    #1;
    n_cmp++; if (read_data_out !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL hit_byte_offset: got %h want deadbeef", read_data_out); end
    tick();
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL hit_req: got %b want 0", mem_req); end
    set_idle();
    tick();
  endtask

  task automatic test_store_hit();
    int st, rc; logic [31:0] ra, rw; logic we, leak, to;
    drive_store(32'h0000_0100, 32'hCAFE_F00D);
    wait_mem(1, 32'h0, st, rc, ra, we, rw, leak, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL st_timeout: got %b want 0", to); end
    n_cmp++; if (st !== 2) begin n_bad++; $display("FAIL st_stalls: got %0d want 2", st); end
    n_cmp++; if (rc !== 1) begin n_bad++; $display("FAIL st_req_cycles: got %0d want 1", rc); end
    n_cmp++; if (ra !== 32'h100) begin n_bad++; $display("FAIL st_addr: got %h want 100", ra); end
    n_cmp++; if (we !== 1'b1) begin n_bad++; $display("FAIL st_we: got %b want 1", we); end
    n_cmp++; if (rw !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL st_wdata: got %h want cafef00d", rw); end
    n_cmp++; if (read_data_out !== 32'h0) begin n_bad++; $display("FAIL st_done_data: got %h want 0", read_data_out); end
    set_idle();
    tick();
    drive_load(32'h0000_0100);
    @(negedge clk);
    n_cmp++; if (mem_stall_out !== 1'b0) begin n_bad++; $display("FAIL st_reload_stall: got %b want 0", mem_stall_out); end
    n_cmp++; if (read_data_out !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL st_reload_data: got %h want cafef00d", read_data_out); end
    set_idle();
    tick();
  endtask

  task automatic test_store_no_alloc();
    int st, rc; logic [31:0] ra, rw; logic we, leak, to;
    drive_store(32'h0000_0200, 32'h1111_2222);
    wait_mem(1, 32'h0, st, rc, ra, we, rw, leak, to);
    n_cmp++; if (st !== 2) begin n_bad++; $display("FAIL na_store_stalls: got %0d want 2", st); end
    set_idle();
    tick();
    drive_load(32'h0000_0200);
    wait_mem(1, 32'h1234_5678, st, rc, ra, we, rw, leak, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL na_timeout: got %b want 0", to); end
    n_cmp++; if (st !== 2) begin n_bad++; $display("FAIL na_load_stalls: got %0d want 2", st); end
    n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL na_load_we: got %b want 0", we); end
    n_cmp++; if (ra !== 32'h200) begin n_bad++; $display("FAIL na_load_addr: got %h want 200", ra); end
    n_cmp++; if (read_data_out !== 32'h1234_5678) begin n_bad++; $display("FAIL na_load_data: got %h want 12345678", read_data_out); end
    set_idle();
    tick();
  endtask

  task automatic test_conflict();
    int st, rc; logic [31:0] ra, rw; logic we, leak, to;
    drive_load(32'h0000_0100);
    wait_mem(1, 32'h0BAD_F00D, st, rc, ra, we, rw, leak, to);
    n_cmp++; if (st !== 2) begin n_bad++; $display("FAIL cf_fill_stalls: got %0d want 2", st); end
    set_idle();
    tick();
    drive_load(32'h0000_0100);
    @(negedge clk);
    n_cmp++; if (mem_stall_out !== 1'b0) begin n_bad++; $display("FAIL cf_cached_stall: got %b want 0", mem_stall_out); end
    set_idle();
    tick();
    drive_load(32'h0000_1100);
    wait_mem(2, 32'hA5A5_A5A5, st, rc, ra, we, rw, leak, to);
    n_cmp++; if (st !== 3) begin n_bad++; $display("FAIL cf_evict_stalls: got %0d want 3", st); end
    n_cmp++; if (ra !== 32'h1100) begin n_bad++; $display("FAIL cf_evict_addr: got %h want 1100", ra); end
    n_cmp++; if (read_data_out !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL cf_evict_data: got %h want a5a5a5a5", read_data_out); end
    set_idle();
    tick();
    drive_load(32'h0000_0100);
    wait_mem(1, 32'h0BAD_F00D, st, rc, ra, we, rw, leak, to);
    n_cmp++; if (st !== 2) begin n_bad++; $display("FAIL cf_remiss_stalls: got %0d want 2", st); end
    n_cmp++; if (read_data_out !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL cf_remiss_data: got %h want 0badf00d", read_data_out); end
    set_idle();
    tick();
  endtask

  task automatic test_reset_mid();
    int st, rc; logic [31:0] ra, rw; logic we, leak, to;
    drive_load(32'h0000_0300);
    tick();
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rm_req_before: got %b want 1", mem_req); end
    set_idle();
    rst = 1'b1;
    tick();
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rm_req_after: got %b want 0", mem_req); end
    n_cmp++; if (mem_stall_out !== 1'b0) begin n_bad++; $display("FAIL rm_stall_after: got %b want 0", mem_stall_out); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL rm_addr_after: got %h want 0", mem_addr); end
    rst = 1'b0;
    tick();
    drive_load(32'h0000_0100);
    wait_mem(1, 32'h55AA_55AA, st, rc, ra, we, rw, leak, to);
    n_cmp++; if (st !== 2) begin n_bad++; $display("FAIL rm_invalidated_stalls: got %0d want 2", st); end
    n_cmp++; if (read_data_out !== 32'h55AA_55AA) begin n_bad++; $display("FAIL rm_refill_data: got %h want 55aa55aa", read_data_out); end
    set_idle();
    tick();
  endtask

  task automatic test_branch();
    int st, rc; logic [31:0] ra, rw; logic we, leak, to;
    branch_in = 1'b1; zero_in = 1'b1; branch_target_in = 32'h0040_0080;
    alu_result_in = 32'h0000_0007; rd_addr_in = 5'd17; mem_to_reg_in = 1'b0;
    #1;
    n_cmp++; if (pc_src_out !== 1'b1) begin n_bad++; $display("FAIL br_taken: got %b want 1", pc_src_out); end
    n_cmp++; if (branch_target_out !== 32'h0040_0080) begin n_bad++; $display("FAIL br_target: got %h want 00400080", branch_target_out); end
    n_cmp++; if (alu_result_out !== 32'h7) begin n_bad++; $display("FAIL br_alu_pass: got %h want 7", alu_result_out); end
    n_cmp++; if (rd_addr_out !== 5'd17) begin n_bad++; $display("FAIL br_rd_pass: got %0d want 17", rd_addr_out); end
    zero_in = 1'b0;
    #1;
    n_cmp++; if (pc_src_out !== 1'b0) begin n_bad++; $display("FAIL br_not_zero: got %b want 0", pc_src_out); end
    branch_in = 1'b0; zero_in = 1'b1;
    #1;
    n_cmp++; if (pc_src_out !== 1'b0) begin n_bad++; $display("FAIL br_no_branch: got %b want 0", pc_src_out); end
    branch_in = 1'b0; zero_in = 1'b0;
    tick();
    drive_load(32'h0000_0400);
    tick();
    branch_in = 1'b1; zero_in = 1'b1;
    @(negedge clk);
    n_cmp++; if (mem_stall_out !== 1'b1) begin n_bad++; $display("FAIL br_stall_state: got %b want 1", mem_stall_out); end
    n_cmp++; if (pc_src_out !== 1'b1) begin n_bad++; $display("FAIL br_taken_in_stall: got %b want 1", pc_src_out); end
    branch_in = 1'b0; zero_in = 1'b0;
    tick();
    wait_mem(1, 32'h0, st, rc, ra, we, rw, leak, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL br_txn_timeout: got %b want 0", to); end
    set_idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_load_miss();
    test_load_hit();
    test_store_hit();
    test_store_no_alloc();
    test_conflict();
    test_reset_mid();
    test_branch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
